// File: rtl/sqrt_frac_iter.sv
// -----------------------------------------------------------------------------
// sqrt_frac_iter
//
// Iterative fraction square-root core. An accepted 24-bit aligned fraction is
// extended to the 48-bit radicand {frac_in, 24'b0}. A restoring
// digit-by-digit algorithm then produces its 24-bit integer square root, one
// root bit per clock. Every operand takes the full 24 iterations. The root,
// the pass-through exponent and a sticky (inexact) flag are presented on a
// valid/ready handshake.
//
// Ports:
//   clk         system clock, rising-edge active
//   rst_n       asynchronous active-low reset
//   in_valid    upstream operand valid
//   in_ready    core idle and able to accept an operand
//   frac_in     24-bit aligned fraction
//   exp_in      8-bit result exponent, passed through unchanged
//   out_valid   result valid (held until out_ready)
//   out_ready   downstream accepts the result
//   root_out    floor(sqrt({frac_in, 24'b0}))
//   exp_out     exponent latched at acceptance
//   sticky_out  final partial remainder non-zero
// -----------------------------------------------------------------------------
module sqrt_frac_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] frac_in,
  input  logic [7:0]  exp_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] root_out,
  output logic [7:0]  exp_out,
  output logic        sticky_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nx_s;

  logic [47:0] rad_r;
  logic [25:0] rem_r;
  logic [23:0] root_r;
  logic [4:0]  cnt_r;

  logic [25:0] rem_shift_s;
  logic [25:0] trial_s;
  logic [25:0] rem_nx_s;
  logic        root_bit_s;
  logic [23:0] root_nx_s;

  logic        accept_s;
  logic        last_s;

  assign accept_s = (state_r == ST_IDLE) && in_valid;
  assign last_s   = (state_r == ST_RUN) && (cnt_r == 5'd0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == 5'd0) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // One restoring iteration: bring down two radicand bits, try {root, 01}.
  // The remainder stays below 2*root + 1 < 2^24 before the final step, so
  // shifting only rem_r[23:0] loses no information.
  always_comb begin
    rem_shift_s = {rem_r[23:0], rad_r[47:46]};
    trial_s     = {root_r, 2'b01};
    if (rem_shift_s >= trial_s) begin
      rem_nx_s   = rem_shift_s - trial_s;
      root_bit_s = 1'b1;
    end else begin
      rem_nx_s   = rem_shift_s;
      root_bit_s = 1'b0;
    end
    root_nx_s = {root_r[22:0], root_bit_s};
  end

  // Iteration datapath: radicand shifter, partial remainder, root, counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad_r  <= 48'd0;
      rem_r  <= 26'd0;
      root_r <= 24'd0;
      cnt_r  <= 5'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            rad_r  <= {frac_in, 24'd0};
            rem_r  <= 26'd0;
            root_r <= 24'd0;
            cnt_r  <= 5'd23;
          end else begin
            rad_r  <= rad_r;
            rem_r  <= rem_r;
            root_r <= root_r;
            cnt_r  <= cnt_r;
          end
        end
        ST_RUN: begin
          rad_r  <= {rad_r[45:0], 2'b00};
          rem_r  <= rem_nx_s;
          root_r <= root_nx_s;
          if (cnt_r != 5'd0) begin
            cnt_r <= cnt_r - 5'd1;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: begin
          rad_r  <= rad_r;
          rem_r  <= rem_r;
          root_r <= root_r;
          cnt_r  <= cnt_r;
        end
      endcase
    end
  end

  // Result registers: exponent captured at acceptance, root/sticky on the
  // final iteration, so the outputs never show partial roots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      root_out   <= 24'd0;
      exp_out    <= 8'd0;
      sticky_out <= 1'b0;
    end else begin
      if (accept_s) begin
        exp_out <= exp_in;
      end else begin
        exp_out <= exp_out;
      end
      if (last_s) begin
        root_out   <= root_nx_s;
        sticky_out <= (rem_nx_s != 26'd0);
      end else begin
        root_out   <= root_out;
        sticky_out <= sticky_out;
      end
    end
  end

  // Registered handshake flags derived from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_nx_s == ST_IDLE);
      out_valid <= (state_nx_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_sqrt_frac_iter.sv
// -----------------------------------------------------------------------------
// tb_sqrt_frac_iter
//
// Self-checking bench for sqrt_frac_iter. It covers directed vectors, output
// backpressure, an asynchronous reset in mid-iteration and a randomized sweep.
// The sweep is compared against an arithmetic square-root reference model.
// -----------------------------------------------------------------------------
module tb_sqrt_frac_iter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] frac_in;
  logic [7:0]  exp_in;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] root_out;
  logic [7:0]  exp_out;
  logic        sticky_out;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [23:0] frac;
    logic [7:0]  exp;
    logic [23:0] root;
    logic        sticky;
  } vec_t;

  vec_t vecs[7];

  sqrt_frac_iter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .frac_in    (frac_in),
    .exp_in     (exp_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .root_out   (root_out),
    .exp_out    (exp_out),
    .sticky_out (sticky_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and report a mismatch.
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: integer square root of frac * 2^24 computed with plain arithmetic.
  function automatic void ref_sqrt(input logic [23:0] f, output logic [23:0] r,
                                   output logic s);
    longint unsigned v;
    longint unsigned q;
    v = {16'd0, f, 24'd0};
    q = longint'($floor($sqrt(real'(v))));
    while (q * q > v) q--;
    while ((q + 64'd1) * (q + 64'd1) <= v) q++;
    r = q[23:0];
    s = (q * q != v);
  endfunction

  // Drive one operand through the core and check latency, result and handshake.
  // stall: DONE cycles with out_ready=0 before release (rnd=0).
  // rnd:   out_ready randomly toggled throughout.
  task automatic run_op(input logic [23:0] f, input logic [7:0] e,
                        input logic [23:0] xr, input logic xs,
                        input int stall, input bit rnd, input string tag);
    int guard;
    int lat;
    int k;
    bit released;
    bit go;
    guard = 0;
    in_valid = 1'b1;
    frac_in = f;
    exp_in = e;
    out_ready = 1'b0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk({tag, "_accept_timeout"}, 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    frac_in = $urandom;
    exp_in = $urandom;
    chk({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1'b0;
      if (rnd) in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'd24);
    if (!out_valid) return;
    chk({tag, "_root"}, 64'(root_out), 64'(xr));
    chk({tag, "_sticky"}, 64'(sticky_out), 64'(xs));
    chk({tag, "_exp"}, 64'(exp_out), 64'(e));
    released = 1'b0;
    k = 0;
    while (!released && k < 200) begin
      if (rnd) go = 1'($urandom_range(0, 1));
      else go = (k >= stall);
      if (!go) begin
        out_ready = 1'b0;
        in_valid = 1'b1;
        frac_in = $urandom;
        exp_in = $urandom;
        @(negedge clk);
        chk({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_stall_ready"}, 64'(in_ready), 64'd0);
        chk({tag, "_stall_root"}, 64'(root_out), 64'(xr));
        chk({tag, "_stall_exp"}, 64'(exp_out), 64'(e));
        chk({tag, "_stall_sticky"}, 64'(sticky_out), 64'(xs));
      end else begin
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_release_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_release_ready"}, 64'(in_ready), 64'd1);
        released = 1'b1;
      end
      k++;
    end
    if (!released) chk({tag, "_release_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    logic [23:0] r;
    logic        s;
    logic [23:0] f;
    n_checks = 0;
    n_errors = 0;

    vecs[0] = '{24'h400000, 8'h7F, 24'h800000, 1'b0};
    vecs[1] = '{24'h800000, 8'h80, 24'hB504F3, 1'b1};
    vecs[2] = '{24'hFFFFFF, 8'hFE, 24'hFFFFFF, 1'b1};
    vecs[3] = '{24'h000001, 8'h01, 24'h001000, 1'b0};
    vecs[4] = '{24'h000000, 8'h00, 24'h000000, 1'b0};
    vecs[5] = '{24'h000004, 8'h35, 24'h002000, 1'b0};
    vecs[6] = '{24'h900000, 8'hA5, 24'hC00000, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    frac_in = 24'd0;
    exp_in = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_root", 64'(root_out), 64'd0);
    chk("reset_exp", 64'(exp_out), 64'd0);
    chk("reset_sticky", 64'(sticky_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table, out_ready high as soon as the result appears.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].frac, vecs[i].exp, vecs[i].root, vecs[i].sticky, 0, 1'b0,
             $sformatf("vec%0d", i));
    end

    // Backpressure: 10 stalled cycles, then the next operand must be correct.
    run_op(24'h800000, 8'h42, 24'hB504F3, 1'b1, 10, 1'b0, "stall");
    run_op(24'h400000, 8'h7F, 24'h800000, 1'b0, 0, 1'b0, "after_stall");

    // Asynchronous reset at iteration 12, away from a clock edge.
    in_valid = 1'b1;
    frac_in = 24'hFFFFFF;
    exp_in = 8'h5A;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_root", 64'(root_out), 64'd0);
    chk("arst_exp", 64'(exp_out), 64'd0);
    chk("arst_sticky", 64'(sticky_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("arst_no_result", 64'(out_valid), 64'd0);
    run_op(24'h000001, 8'h33, 24'h001000, 1'b0, 0, 1'b0, "after_arst");

    // Random sweep against the reference model with random out_ready.
    for (int i = 0; i < 1500; i++) begin
      case (i % 4)
        0: f = 24'($urandom);
        1: f = 24'($urandom) & 24'h0000FF;
        2: f = 24'($urandom) | 24'hC00000;
        default: f = 24'($urandom) >> $urandom_range(0, 23);
      endcase
      ref_sqrt(f, r, s);
      run_op(f, 8'($urandom), r, s, 0, 1'b1, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
